// File: rtl/sram_delay_pkg.sv
// Shared types and widths for the delay-line SRAM responder.
package sram_delay_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int SRAM_ADDR_W = 18;

    typedef enum logic [2:0] {IDLE, READ, TURN, WRITE, HOLD} sram_state_t;

endpackage

// File: rtl/sram_delay_ctrl_edge_sync.sv
// Two-flop synchroniser plus a delay flop; pulses rise for one cycle per
// rising edge of an asynchronous input (ADCLRCK, DACLRCK, BCLK).
module edge_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/sram_delay_ctrl.sv
// Serves one read-then-optional-write request per ADCLRCK rising edge
// against the external asynchronous SRAM; all SRAM pins are registered.
module sram_delay_ctrl
    import sram_delay_pkg::*;
#(
    parameter logic [1:0] BANK        = 2'b00,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   ADCLRCK,
    input  logic [SAMPLE_W-1:0]    D,
    input  logic [15:0]            write_address,
    input  logic [15:0]            read_address,
    input  logic                   W_E,
    output logic [SAMPLE_W-1:0]    Q,
    output logic                   q_valid,
    output logic                   busy,
    output logic                   overrun,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SAMPLE_W-1:0]    SRAM_DQ,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output sram_state_t            dbg_state
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    sram_state_t         state;
    logic [3:0]          cnt;
    logic [SAMPLE_W-1:0] lat_d;
    logic [15:0]         lat_wa;
    logic                lat_we;
    logic                dq_oe;
    logic [SAMPLE_W-1:0] dq_out;
    logic                rise;

    edge_sync u_lrck_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .async_in (ADCLRCK),
        .rise     (rise)
    );

    // Pin registers are loaded with the values of the state being entered,
    // so every strobe changes on the same edge as the state itself.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_d     <= '0;
            lat_wa    <= '0;
            lat_we    <= 1'b0;
            Q         <= '0;
            q_valid   <= 1'b0;
            overrun   <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            q_valid <= 1'b0;
            if (rise && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (rise) begin
                        lat_d     <= D;
                        lat_wa    <= write_address;
                        lat_we    <= W_E;
                        cnt       <= CNT_LOAD;
                        SRAM_ADDR <= {BANK, read_address};
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= 1'b0;
                        SRAM_UB_N <= 1'b0;
                        SRAM_LB_N <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (cnt == 4'd0) begin
                        Q         <= SRAM_DQ;
                        q_valid   <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        state     <= TURN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                TURN: begin
                    if (lat_we) begin
                        cnt       <= CNT_LOAD;
                        SRAM_ADDR <= {BANK, lat_wa};
                        SRAM_WE_N <= 1'b0;
                        dq_oe     <= 1'b1;
                        dq_out    <= lat_d;
                        state     <= WRITE;
                    end else begin
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WRITE: begin
                    if (cnt == 4'd0) begin
                        SRAM_WE_N <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    SRAM_CE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                    SRAM_UB_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                    dq_oe     <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {SAMPLE_W{1'bz}};
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_sram_delay_ctrl.sv
// Directed bench for sram_delay_ctrl with a behavioural async SRAM model.
module tb_sram_delay_ctrl;
    import sram_delay_pkg::*;

    logic        CLOCK_50;
    logic        reset;
    logic        ADCLRCK;
    logic [15:0] D;
    logic [15:0] write_address;
    logic [15:0] read_address;
    logic        W_E;
    logic [15:0] Q;
    logic        q_valid;
    logic        busy;
    logic        overrun;
    logic [17:0] SRAM_ADDR;
    tri1  [15:0] SRAM_DQ;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    sram_state_t dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [0:1023];

    sram_delay_ctrl dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .ADCLRCK       (ADCLRCK),
        .D             (D),
        .write_address (write_address),
        .read_address  (read_address),
        .W_E           (W_E),
        .Q             (Q),
        .q_valid       (q_valid),
        .busy          (busy),
        .overrun       (overrun),
        .SRAM_ADDR     (SRAM_ADDR),
        .SRAM_DQ       (SRAM_DQ),
        .SRAM_CE_N     (SRAM_CE_N),
        .SRAM_OE_N     (SRAM_OE_N),
        .SRAM_WE_N     (SRAM_WE_N),
        .SRAM_UB_N     (SRAM_UB_N),
        .SRAM_LB_N     (SRAM_LB_N),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // SRAM model: drives on read, captures on WE_N rising edge; bus floats high otherwise.
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

    always @(posedge SRAM_WE_N) begin
        if (SRAM_CE_N === 1'b0)
            mem[SRAM_ADDR[9:0]] = SRAM_DQ;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Driver: issue one request and observe the busy window cycle by cycle.
    task automatic run_req(input logic [15:0] wa, input logic [15:0] ra, input logic [15:0] d,
                           input logic we, input bit glitch,
                           output int busy_n, output int qv_idx, output int qv_n,
                           output logic [15:0] q_seen, output logic [17:0] rd_a,
                           output int we_low, output int dq_drv);
        int t;
        busy_n = 0; qv_idx = 0; qv_n = 0; q_seen = '0; rd_a = '0; we_low = 0; dq_drv = 0;
        @(negedge CLOCK_50);
        write_address = wa; read_address = ra; D = d; W_E = we; ADCLRCK = 1'b1;
        t = 0;
        do begin
            @(negedge CLOCK_50);
            t++;
        end while (!busy && t < 10);
        if (!busy) begin
            chk("accept_timeout", 32'd0, 32'd1);
            ADCLRCK = 1'b0;
            return;
        end
        while (busy && busy_n < 40) begin
            busy_n++;
            if (busy_n == 1) begin
                rd_a = SRAM_ADDR;
                ADCLRCK = 1'b0;
                D = 16'($urandom_range(0, 16'hFFFE));
                write_address = 16'($urandom_range(100, 900));
                read_address  = 16'($urandom_range(100, 900));
                W_E = 1'($urandom_range(0, 1));
            end
            if (glitch && busy_n == 2) ADCLRCK = 1'b1;
            if (q_valid) begin
                qv_n++;
                qv_idx = busy_n;
                q_seen = Q;
            end
            if (!SRAM_WE_N) we_low++;
            if (SRAM_OE_N && SRAM_DQ != 16'hFFFF) dq_drv++;
            @(negedge CLOCK_50);
        end
        ADCLRCK = 1'b0;
        repeat (20) begin
            if (q_valid) qv_n++;
            @(negedge CLOCK_50);
        end
    endtask

    int          bn, qi, qn, wl, dd, t;
    logic [15:0] qs;
    logic [17:0] ra_seen;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[3] = 16'h0303;
        mem[7] = 16'hAAAA;
        mem[9] = 16'h0909;
        reset = 1'b1; ADCLRCK = 1'b0; D = '0; write_address = '0; read_address = '0; W_E = 1'b0;

        // Reset with ADCLRCK toggling
        repeat (3) begin
            @(negedge CLOCK_50);
            ADCLRCK = ~ADCLRCK;
        end
        @(negedge CLOCK_50);
        ADCLRCK = 1'b0;
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
        chk("rst_ctrl_n", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        chk("rst_dq_float", 32'(SRAM_DQ), 32'hFFFF);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);

        // Write 1234 to 5 (reading 3), then read 5 back
        run_req(16'd5, 16'd3, 16'h1234, 1'b1, 1'b0, bn, qi, qn, qs, ra_seen, wl, dd);
        chk("wr_busy", 32'(bn), 32'd6);
        chk("wr_q_old", 32'(qs), 32'h0303);
        chk("wr_we_low", 32'(wl), 32'd2);
        chk("wr_dq_drv", 32'(dd), 32'd3);
        chk("wr_mem5", 32'(mem[5]), 32'h1234);
        run_req(16'd40, 16'd5, 16'h0BAD, 1'b0, 1'b0, bn, qi, qn, qs, ra_seen, wl, dd);
        chk("rd5_q", 32'(qs), 32'h1234);
        chk("rd5_qv_idx", 32'(qi), 32'd3);
        chk("rd5_qv_n", 32'(qn), 32'd1);
        chk("rd5_addr", 32'(ra_seen), 32'h00005);
        chk("rd5_busy", 32'(bn), 32'd3);
        chk("rd5_q_held", 32'(Q), 32'h1234);
        chk("rd5_mem40", 32'(mem[40]), 32'h0);

        // Read-before-write on the same address
        run_req(16'd7, 16'd7, 16'h5555, 1'b1, 1'b0, bn, qi, qn, qs, ra_seen, wl, dd);
        chk("rbw_q", 32'(qs), 32'hAAAA);
        chk("rbw_mem7", 32'(mem[7]), 32'h5555);
        chk("rbw_busy", 32'(bn), 32'd6);
        chk("rbw_qv_idx", 32'(qi), 32'd3);

        // Read only
        run_req(16'd9, 16'd9, 16'h7777, 1'b0, 1'b0, bn, qi, qn, qs, ra_seen, wl, dd);
        chk("ro_q", 32'(qs), 32'h0909);
        chk("ro_we_low", 32'(wl), 32'd0);
        chk("ro_dq_drv", 32'(dd), 32'd0);
        chk("ro_busy", 32'(bn), 32'd3);
        chk("ro_mem9", 32'(mem[9]), 32'h0909);
        chk("ro_overrun", 32'(overrun), 32'd0);

        // Overrun: second rise lands inside the transaction
        run_req(16'd11, 16'd5, 16'h6789, 1'b1, 1'b1, bn, qi, qn, qs, ra_seen, wl, dd);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_qv_n", 32'(qn), 32'd1);
        chk("ovr_q", 32'(qs), 32'h1234);
        chk("ovr_busy", 32'(bn), 32'd6);
        chk("ovr_mem11", 32'(mem[11]), 32'h6789);
        chk("ovr_idle", 32'(busy), 32'd0);

        // Reset in the first WRITE cycle
        @(negedge CLOCK_50);
        write_address = 16'd20; read_address = 16'd21; D = 16'hBEEF; W_E = 1'b1; ADCLRCK = 1'b1;
        t = 0;
        while (SRAM_WE_N && t < 20) begin
            @(negedge CLOCK_50);
            if (busy) ADCLRCK = 1'b0;
            t++;
        end
        chk("rmw_reached_write", 32'(SRAM_WE_N), 32'd0);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("rmw_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rmw_oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("rmw_dq_float", 32'(SRAM_DQ), 32'hFFFF);
        chk("rmw_state", 32'(dbg_state), 32'(IDLE));
        chk("rmw_overrun", 32'(overrun), 32'd0);
        chk("rmw_busy", 32'(busy), 32'd0);
        ADCLRCK = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);

        // Recovery after reset
        run_req(16'd41, 16'd5, 16'h0001, 1'b0, 1'b0, bn, qi, qn, qs, ra_seen, wl, dd);
        chk("post_rst_q", 32'(qs), 32'h1234);
        chk("post_rst_busy", 32'(bn), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_delay_ctrl.md
# sram_delay_ctrl

Memory-side responder for the delay-line effects (vibrato, echo, chorus). Once per audio sample, an effect presents a write address, write data, write enable and read address, all clocked by the codec's `ADCLRCK`. This block serves that request from the board's external 256K×16 asynchronous SRAM on `CLOCK_50` and returns the read sample on `Q`. It reads before it writes, so a request with equal read and write addresses returns the old contents, which is a full-buffer delay.

## Interface
- `BANK`, default 2'b00: upper SRAM address bits; `SRAM_ADDR = {BANK, addr[15:0]}`.
- `WAIT_CYCLES`, default 2: `CLOCK_50` cycles per SRAM read or write strobe; legal range 1–15.
- `CLOCK_50`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `ADCLRCK`  in  1  codec LR clock, asynchronous to `CLOCK_50`; a rising edge is one request.
- `D`  in  16  sample to write.
- `write_address`  in  16  write address.
- `read_address`  in  16  read address.
- `W_E`  in  1  write enable for this request.
- `Q`  out  16  last sample read; held until the next capture.
- `q_valid`  out  1  one-cycle pulse when `Q` updates.
- `busy`  out  1  high whenever the state is not IDLE.
- `overrun`  out  1  sticky; cleared only by reset.
- `SRAM_ADDR`  out  18  SRAM address.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  SRAM active-low controls.

## Operation
- `ADCLRCK` passes through a 2-FF synchroniser plus a third FF. `rise = s2 & ~s3`.
- States: IDLE, READ, TURN, WRITE, HOLD.
- IDLE, on `rise`:
  - latch `D`, `write_address`, `read_address`, `W_E`;
  - go to READ.
- READ, `WAIT_CYCLES` cycles:
  - `CE_N=0`, `OE_N=0`, `WE_N=1`, `UB_N=LB_N=0`;
  - `ADDR={BANK, rd_addr}`, DQ released (high-Z);
  - on the last READ cycle's clock edge, `Q <= SRAM_DQ`.
- TURN, 1 cycle: `OE_N=1`, `CE_N=0`, DQ high-Z. Next state is WRITE if the latched `W_E` is 1, otherwise IDLE.
- WRITE, `WAIT_CYCLES` cycles: `WE_N=0`, `ADDR={BANK, wr_addr}`, DQ driven with the latched `D`.
- HOLD, 1 cycle: `WE_N=1`; DQ and ADDR held, giving data hold after the WE rising edge. Then go to IDLE.
- IDLE outputs: `CE_N=OE_N=WE_N=UB_N=LB_N=1`, DQ high-Z, `ADDR` holds its last value.
- All SRAM controls are registered, with no combinational paths to the pins. DQ is driven only in WRITE and HOLD.
- A `rise` seen in any state other than IDLE sets `overrun`; that request is dropped and the in-progress transaction is unaffected.
- Inputs are sampled only at acceptance, so changes during `busy` are ignored.
- Addresses pass through unchanged with no wrap logic; each effect owns its own modulo arithmetic.

## Timing
- Reset values:
  - `Q=0`, `q_valid=0`, `busy=0`, `overrun=0`;
  - `SRAM_ADDR=0`, all `*_N=1`, DQ high-Z;
  - state IDLE, synchroniser FFs 0.
- Reset mid-transaction takes effect at the next edge: `WE_N` and `OE_N` go high and DQ is released. The interrupted write may be partial.
- Latency from the `ADCLRCK` pin edge to `rise` is 2–3 cycles.
- Acceptance is at cycle A. READ occupies A+1 to A+WAIT_CYCLES.
- `Q` is valid and `q_valid=1` at cycle A+WAIT_CYCLES+1, which is the TURN cycle.
- Total `busy` cycles:
  - 2·WAIT_CYCLES+2 with a write (6 at default);
  - WAIT_CYCLES+1 without a write (3 at default).
- The 48 kHz request period is about 1041 cycles, so overrun indicates a fault such as a glitching `ADCLRCK`.

## Structure
- Package `sram_delay_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, READ, TURN, WRITE, HOLD} sram_state_t`;
  - `SAMPLE_W=16`, `SRAM_ADDR_W=18`.
- Sub-module `edge_sync` contains the 2-FF synchroniser, the delay FF and rising-edge detect (`CLOCK_50`, `reset`, `async_in` → `rise`). It is reused for `BCLK` and `DACLRCK`.
- Wait counter is 4-bit, loaded on entry to READ and to WRITE.

## Test plan
- Reset: assert `reset` for 3 cycles with `ADCLRCK` toggling → all outputs at reset values, no `*_N` low, DQ high-Z, `busy=0`.
- Write then read: request `wr=5`, `D=16'h1234`, `W_E=1`; next request `rd=5`, `W_E=0` → `Q=16'h1234`, `q_valid` pulses at A+3, `SRAM_ADDR=18'h00005`.
- Read-before-write: SRAM model at address 7 holds `16'hAAAA`; request `rd=wr=7`, `D=16'h5555` → `Q=16'hAAAA`, model holds `16'h5555` afterwards, `busy` for exactly 6 cycles.
- `W_E=0`: request `rd=9` → `SRAM_WE_N` never low, DQ never driven, `busy` for 3 cycles.
- Overrun: second `ADCLRCK` rise 3 cycles after acceptance → `overrun=1` and stays set, first transaction completes normally, no second `q_valid`.
- Reset mid-write: assert `reset` in the first WRITE cycle → `SRAM_WE_N=1` and DQ high-Z at the next edge, state IDLE, `overrun=0`.
